// File: rtl/seq_add_n.sv
// seq_add_n: digit-serial adder/subtractor.
// Operands are captured on start, then DIGIT bits per clock are added
// LSB-first through a stored carry. The finished result, carry-out and
// signed overflow are loaded into the output registers in one edge.
module seq_add_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] wa, wb, wsum, wsum_nxt;
  logic             wcarry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last;
  logic             accept;

  // Digit adder: low DIGIT bits of the working operands plus the stored
  // carry. The carry into the top bit of the digit is recovered as
  // sum ^ a ^ b, which gives the carry into bit WIDTH-1 on the last digit.
  always_comb begin
    dsum     = {1'b0, wa[DIGIT-1:0]} + {1'b0, wb[DIGIT-1:0]} + {{DIGIT{1'b0}}, wcarry};
    wsum_nxt = (wsum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    msb_cin  = dsum[DIGIT-1] ^ wa[DIGIT-1] ^ wb[DIGIT-1];
    last     = (state == RUN) && (cnt == LAST);
    accept   = (state != RUN) && start;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs; start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: subtraction is folded in at capture time as a + ~b + ~cin,
  // so the serial loop is always a plain add. Outputs change only on the
  // final digit so partial sums are never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa     <= '0;
      wb     <= '0;
      wsum   <= '0;
      wcarry <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      wa     <= a;
      wb     <= sub ? ~b : b;
      wcarry <= sub ? ~cin : cin;
      wsum   <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      wa     <= wa >> DIGIT;
      wb     <= wb >> DIGIT;
      wcarry <= dsum[DIGIT];
      wsum   <= wsum_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= wsum_nxt;
        cout <= dsum[DIGIT];
        ovf  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_seq_add_n.sv
// Testbench for seq_add_n: one bit-serial instance and one 4-bit-digit
// instance, with expected results queued when an operation is started and
// compared when done is seen.
module tb_seq_add_n;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  exp_t q1[$];
  exp_t q4[$];
  int   npass = 0;
  int   ntotal = 0;

  seq_add_n #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  seq_add_n #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  // Reference model written from the arithmetic definition.
  function automatic exp_t model(input logic [7:0] aa, input logic [7:0] bb,
                                 input logic s, input logic c);
    exp_t       e;
    logic [7:0] bx;
    logic [8:0] t;
    bx   = s ? ~bb : bb;
    t    = {1'b0, aa} + {1'b0, bx} + {8'b0, (s ? ~c : c)};
    e.s  = t[7:0];
    e.co = t[8];
    e.ov = (aa[7] == bx[7]) && (t[7] != aa[7]);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic applyStimulus(input logic [7:0] aa, input logic [7:0] bb,
                               input logic s, input logic c, input exp_t e);
    a   = aa;
    b   = bb;
    sub = s;
    cin = c;
    q1.push_back(e);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // Run one operation on the bit-serial instance; optionally pulse start
  // with different operands inject cycles into RUN.
  task automatic runOp1(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic s, input logic c, input exp_t e, input int inject);
    int   n;
    int   busycnt;
    exp_t got;
    applyStimulus(aa, bb, s, c, e);
    n = 0;
    busycnt = 0;
    while (!done1 && n < 20) begin
      if (busy1) busycnt++;
      start1 = (n == inject);
      if (n == inject) begin
        a = 8'hA5;
        b = 8'h5A;
        sub = ~sub;
      end
      @(posedge clk); #1;
      n++;
    end
    start1 = 1'b0;
    checkOutput({tag, "_latency"}, n, 8);
    checkOutput({tag, "_busycycles"}, busycnt, 8);
    checkOutput({tag, "_busy_in_done"}, busy1, 0);
    checkOutput({tag, "_sb_depth"}, q1.size(), 1);
    if (q1.size() != 0) begin
      got = q1.pop_front();
      checkOutput({tag, "_sum"}, sum1, got.s);
      checkOutput({tag, "_cout"}, cout1, got.co);
      checkOutput({tag, "_ovf"}, ovf1, got.ov);
    end
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, done1, 0);
    checkOutput({tag, "_hold"}, {sum1, cout1, ovf1}, {e.s, e.co, e.ov});
  endtask

  initial begin
    exp_t e;
    exp_t got;
    int   n;
    int   seen;
    logic [7:0] ra, rb;
    logic       rs, rc;

    // Reset asserted before any clock edge
    #3;
    checkOutput("reset1", {busy1, done1, sum1, cout1, ovf1}, 0);
    checkOutput("reset4", {busy4, done4, sum4, cout4, ovf4}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Start accepted on the first edge after reset release
    e = '{s: 8'h00, co: 1'b1, ov: 1'b0};
    runOp1("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, e, -1);
    e = '{s: 8'h80, co: 1'b0, ov: 1'b1};
    runOp1("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, e, -1);
    e = '{s: 8'hFE, co: 1'b0, ov: 1'b0};
    runOp1("05_minus_07", 8'h05, 8'h07, 1'b1, 1'b0, e, -1);
    e = '{s: 8'h7F, co: 1'b1, ov: 1'b1};
    runOp1("80_minus_01", 8'h80, 8'h01, 1'b1, 1'b0, e, -1);

    // Start during RUN must be ignored
    runOp1("ignore_start", 8'h3C, 8'h11, 1'b0, 1'b0, model(8'h3C, 8'h11, 1'b0, 1'b0), 3);

    // Reset during the 4th RUN cycle aborts with no done
    a = 8'h55; b = 8'h33; sub = 1'b0; cin = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs", {busy1, done1, sum1, cout1, ovf1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen++;
    end
    checkOutput("midreset_no_done", seen, 0);
    runOp1("10_plus_20", 8'h10, 8'h20, 1'b0, 1'b0, '{s: 8'h30, co: 1'b0, ov: 1'b0}, -1);

    // A few random operations against the model
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      runOp1("random", ra, rb, rs, rc, model(ra, rb, rs, rc), -1);
    end

    // DIGIT=4 instance: latency NDIG, then back-to-back start held in DONE
    a = 8'h9C; b = 8'h77; sub = 1'b0; cin = 1'b1;
    q4.push_back('{s: 8'h14, co: 1'b1, ov: 1'b0});
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    checkOutput("d4_busy_after_capture", busy4, 1);
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("d4_latency", n, 2);
    checkOutput("d4_sb_depth", q4.size(), 1);
    if (q4.size() != 0) begin
      got = q4.pop_front();
      checkOutput("d4_sum", sum4, got.s);
      checkOutput("d4_cout", cout4, got.co);
      checkOutput("d4_ovf", ovf4, got.ov);
    end
    a = 8'hF0; b = 8'h0F; sub = 1'b1; cin = 1'b0;
    q4.push_back(model(8'hF0, 8'h0F, 1'b1, 1'b0));
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    checkOutput("d4_backtoback_busy", {busy4, done4}, 2'b10);
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("d4_latency2", n, 2);
    checkOutput("d4_sb_depth2", q4.size(), 1);
    if (q4.size() != 0) begin
      got = q4.pop_front();
      checkOutput("d4_sum2", sum4, got.s);
      checkOutput("d4_cout2", cout4, got.co);
      checkOutput("d4_ovf2", ovf4, got.ov);
    end
    @(posedge clk); #1;
    checkOutput("d4_done_pulse", done4, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
